// File: rtl/check_scan_ctrl_pkg.sv
// Shared definitions for the check/scan controller: FSM state encoding and
// the residue/modulus pair the checker tests every swept value against.
package check_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // A value is a hit when value mod HIT_MODULUS equals HIT_RESIDUE.
  localparam int unsigned HIT_MODULUS = 32'd4;
  localparam int unsigned HIT_RESIDUE = 32'd1;

endpackage

// File: rtl/check_scan_ctrl_if.sv
// Control and output-stream bundle of the check/scan controller.
// slave is the controller side, master is the requester/consumer side.
interface check_scan_ctrl_if #(
  parameter int W = 4
) ();

  logic         start;
  logic         abort;
  logic         out_ready;
  logic         out_valid;
  logic [W:0]   out_val;
  logic         out_hit;
  logic         busy;
  logic         done;
  logic [W:0]   hit_cnt;

  modport master (
    output start, abort, out_ready,
    input  out_valid, out_val, out_hit, busy, done, hit_cnt
  );

  modport slave (
    input  start, abort, out_ready,
    output out_valid, out_val, out_hit, busy, done, hit_cnt
  );

endinterface

// File: rtl/check_scan_ctrl_mod4_hit.sv
// Purely combinational checker: flags values whose residue mod 4 is 1.
module mod4_hit #(
  parameter int W = 4
) (
  input  logic [W:0] val,
  output logic       hit
);
  import check_scan_ctrl_pkg::*;

  localparam logic [W:0] MOD_C = (W+1)'(HIT_MODULUS);
  localparam logic [W:0] RES_C = (W+1)'(HIT_RESIDUE);

  // The modulus is a power of two, so this reduces to a low-bit compare.
  assign hit = ((val % MOD_C) == RES_C);

endmodule

// File: rtl/check_scan_ctrl.sv
// Check/scan controller: sweeps a (W+1)-bit index from 0 to its maximum over
// a valid/ready stream, reporting the checker result for each value.
// Optional hit counter built only when CHECK_SCAN_HITCNT_EN is defined;
// otherwise hit_cnt is tied to zero.
module check_scan_ctrl #(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst,
  check_scan_ctrl_if.slave  bus
);
  import check_scan_ctrl_pkg::*;

  localparam logic [W:0] ZERO_C = {(W+1){1'b0}};
  localparam logic [W:0] ONE_C  = {{W{1'b0}}, 1'b1};
  localparam logic [W:0] LAST_C = {(W+1){1'b1}};

  state_t     state_r;
  state_t     state_nxt_s;
  logic [W:0] idx_r;
  logic       hit_s;
  logic       valid_s;
  logic       busy_s;
  logic       done_s;
  logic       accept_s;
  logic       xfer_s;
  logic       last_s;

  assign accept_s = (state_r == IDLE) && bus.start;
  assign xfer_s   = (state_r == SCAN) && bus.out_ready;
  assign last_s   = (idx_r == LAST_C);

  mod4_hit #(.W(W)) u_mod4_hit (
    .val (idx_r),
    .hit (hit_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort beats a simultaneous final transfer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          state_nxt_s = IDLE;
        end else if (xfer_s && last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from the registered state only
  always_comb begin
    valid_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
      SCAN: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
        done_s  = 1'b0;
      end
      DONE: begin
        valid_s = 1'b0;
        busy_s  = 1'b1;
        done_s  = 1'b1;
      end
      default: begin
        valid_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // Sweep index: cleared on accepted start, steps only on non-final transfers
  // so the value after the maximum is never presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= ZERO_C;
    end else if (accept_s) begin
      idx_r <= ZERO_C;
    end else if (xfer_s && !last_s) begin
      idx_r <= idx_r + ONE_C;
    end else begin
      idx_r <= idx_r;
    end
  end

  assign bus.out_valid = valid_s;
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;
  assign bus.out_val   = idx_r;
  assign bus.out_hit   = hit_s;

`ifdef CHECK_SCAN_HITCNT_EN
  logic [W:0] hit_cnt_r;

  // Hit counter: counts hit transfers (including one coinciding with abort),
  // holds through IDLE until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_r <= ZERO_C;
    end else if (accept_s) begin
      hit_cnt_r <= ZERO_C;
    end else if (xfer_s && hit_s) begin
      hit_cnt_r <= hit_cnt_r + ONE_C;
    end else begin
      hit_cnt_r <= hit_cnt_r;
    end
  end

  assign bus.hit_cnt = hit_cnt_r;
`else
  assign bus.hit_cnt = ZERO_C;
`endif

endmodule

// File: tb/tb_check_scan_ctrl.sv
// Scoreboard bench for check_scan_ctrl (W=4). Stimulus pushes the expected
// beats; a negedge monitor pops and compares on every transfer.
// Expected hit_cnt follows CHECK_SCAN_HITCNT_EN (zero when undefined).
module tb_check_scan_ctrl;

  localparam int W = 4;

`ifdef CHECK_SCAN_HITCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    int val;
    int hit;
    int cnt;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  check_scan_ctrl_if #(.W(W)) bus ();

  check_scan_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  function automatic int exp_cnt(input int c);
    return CNT_ON ? c : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats 0..hi of a fresh sweep; cnt is hit_cnt shown with that beat
  task automatic push_upto(input int hi);
    int c;
    c = 0;
    for (int v = 0; v <= hi; v++) begin
      exp_q.push_back('{v, ((v % 4) == 1) ? 1 : 0, exp_cnt(c)});
      if ((v % 4) == 1) c++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // From cycle n0 after start, wait for done; it must appear in cycle exp_n
  task automatic wait_done(input int n0, input int exp_n, input int final_cnt,
                           input bit start_in_done);
    int n;
    int d0;
    n  = n0;
    d0 = done_cnt;
    while (bus.done !== 1'b1 && n < 45) begin
      tick();
      n++;
    end
    chk("done_cycle", n, exp_n);
    chk("done_busy", bus.busy, 1);
    chk("done_valid", bus.out_valid, 0);
    if (start_in_done) bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("post_done_busy", bus.busy, 0);
    chk("post_done_done", bus.done, 0);
    chk("post_done_valid", bus.out_valid, 0);
    chk("final_hit_cnt", bus.hit_cnt, exp_cnt(final_cnt));
    chk("done_pulses", done_cnt - d0, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: compare every transfer against the scoreboard; count done pulses
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) done_cnt++;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", bus.out_val, 32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_val", bus.out_val, b.val);
        chk("beat_hit", bus.out_hit, b.hit);
        chk("beat_hit_cnt", bus.hit_cnt, b.cnt);
      end
    end
  end

  initial begin
    int d0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset, with start and abort high to show reset overrides them
    rst = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_val", bus.out_val, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hit_cnt", bus.hit_cnt, 0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_busy", bus.busy, 0);

    // Full sweep: 0..31 back to back, done in cycle 33, 8 hits
    push_upto(31);
    bus.out_ready = 1'b1;
    do_start();
    chk("first_valid", bus.out_valid, 1);
    chk("first_val", bus.out_val, 0);
    wait_done(1, 33, 8, 1'b0);

    // Backpressure at value 5 for 3 cycles
    push_upto(31);
    do_start();
    for (int i = 0; i < 5; i++) tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_val", bus.out_val, 5);
      chk("stall_hit", bus.out_hit, 1);
      chk("stall_hit_cnt", bus.hit_cnt, exp_cnt(1));
    end
    bus.out_ready = 1'b1;
    wait_done(9, 36, 8, 1'b1);

    // Abort after the transfer of 9 (value 10 transfers in the abort cycle)
    push_upto(10);
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < 10; i++) tick();
    chk("pre_abort_val", bus.out_val, 10);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_hit_cnt", bus.hit_cnt, exp_cnt(3));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
    chk("idle_abort_busy", bus.busy, 0);
    chk("idle_hold_hit_cnt", bus.hit_cnt, exp_cnt(3));
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_queue_empty", exp_q.size(), 0);

    // Start pulse while scanning at value 12 is ignored
    push_upto(31);
    do_start();
    for (int i = 0; i < 12; i++) tick();
    chk("busy_start_val", bus.out_val, 12);
    do_start();
    chk("no_restart_val", bus.out_val, 13);
    wait_done(14, 33, 8, 1'b0);

    // Reset at value 20, then a fresh sweep from 0
    push_upto(19);
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < 20; i++) tick();
    chk("pre_rst_val", bus.out_val, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_val", bus.out_val, 0);
    chk("mid_rst_hit_cnt", bus.hit_cnt, 0);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_queue_empty", exp_q.size(), 0);
    push_upto(31);
    do_start();
    chk("restart_val", bus.out_val, 0);
    chk("restart_hit_cnt", bus.hit_cnt, 0);
    wait_done(1, 33, 8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/check_scan_ctrl.md
CHECK_SCAN_CTRL -- requirements
Module: check_scan_ctrl

Interface
REQ-001 Parameter: W, default 4, checked-value width is W+1 bits; sweep range 0 .. 2^(W+1)-1.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate the sweep in progress.
REQ-007 out_ready  input  1  consumer accepts the current output beat.
REQ-008 out_valid  output  1  out_val and out_hit are valid.
REQ-009 out_val  output  W+1  value currently presented to the checker.
REQ-010 out_hit  output  1  checker result for out_val: 1 iff out_val mod 4 == 1, i.e. (out_val+3) mod 4 == 0.
REQ-011 busy  output  1  state != IDLE.
REQ-012 done  output  1  one-cycle pulse marking sweep completion.
REQ-013 hit_cnt  output  W+1  number of hits transferred in the current or last sweep.

Function
REQ-014 FSM states: IDLE, SCAN and DONE.
- IDLE->SCAN: on start.
- SCAN->DONE: on transfer of the final value.
- SCAN->IDLE: on abort.
- DONE->IDLE: unconditionally after one cycle.
REQ-015 Start acceptance: a start sampled high in IDLE at edge t SHALL clear the index and hit_cnt, so that out_valid=1 and out_val=0 from cycle t+1.
REQ-016 Transfers: a transfer occurs when out_valid && out_ready; only then SHALL the index increment by 1.
REQ-017 Backpressure: while out_valid=1 and out_ready=0, out_val and out_hit SHALL be held stable.
REQ-018 Hit counting: on each transfer with out_hit=1, hit_cnt SHALL increment by 1; hit_cnt never wraps, since the maximum is 2^(W-1).
REQ-019 Final value: the transfer of value 2^(W+1)-1 SHALL move the FSM to DONE, with no index wrap to 0 presented.
REQ-020 DONE cycle: done=1, out_valid=0, busy=1; hit_cnt SHALL hold its final value through IDLE until the next accepted start.
REQ-021 Start outside IDLE: start SHALL be ignored in SCAN and DONE.
REQ-022 Abort: abort in SCAN SHALL move the FSM to IDLE at the next edge with done held at 0.
REQ-023 Abort during a transfer: a transfer completing in the same cycle SHALL still count toward hit_cnt.
REQ-024 Abort in the final cycle: abort on the final-value transfer cycle SHALL win, giving IDLE with no done pulse.
REQ-025 Abort outside SCAN: abort SHALL be ignored in IDLE and DONE.
REQ-026 Combinational path: out_hit is combinational from registered out_val, through the checker sub-module only; there is no combinational path from inputs to outputs.
REQ-027 Sweep length: with out_ready tied high, a full sweep SHALL take 2^(W+1) SCAN cycles plus 1 DONE cycle.

Reset
REQ-028 rst=1 at a rising edge SHALL force the following, overriding start and abort:
- state=IDLE
- out_valid=0
- out_val=0
- busy=0
- done=0
- hit_cnt=0
REQ-029 Reset mid-sweep SHALL discard all progress; done SHALL NOT pulse.

Configuration
REQ-030 Macro CHECK_SCAN_HITCNT_EN: when defined, the hit counter is built per REQ-018/020.
REQ-031 When CHECK_SCAN_HITCNT_EN is undefined, hit_cnt SHALL be constant 0 and no counter register is synthesized; all other behaviour is unchanged.

Structure
REQ-032 Shared package: holds the FSM state enum (IDLE, SCAN, DONE) and the hit-residue constant (1, modulus 4).
REQ-033 Sub-module: the checker is a separate instance named mod4_hit.
- Parameter W; input W+1 bits; output 1 bit.
- Purely combinational.
- check_scan_ctrl instantiates exactly one mod4_hit.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- Full sweep: W=4, out_ready=1, start pulse -> out_val 0..31 on consecutive cycles; out_hit=1 exactly at 1,5,9,...,29; done pulses 33 cycles after start; hit_cnt=8.
- Backpressure: out_ready low for 3 cycles while out_val=5 -> out_val=5 and out_hit=1 held; hit_cnt increments once only.
- Abort: abort asserted after the transfer of value 9 -> next cycle busy=0 and done never pulses; hit_cnt=3.
- Start while busy: start pulse at out_val=12 -> sweep continues to 31 without restart; hit_cnt=8.
- Reset mid-sweep: rst at out_val=20, then start -> sweep restarts at 0 with hit_cnt=0 at the first beat.
- Macro off: CHECK_SCAN_HITCNT_EN undefined, full sweep -> hit_cnt=0 throughout; out_val/out_hit/done timing identical to the full-sweep scenario.
